// File: rtl/gray_ptr_sync_decoder.sv
// Receive side of an async FIFO pointer crossing: synchronizes a remote Gray
// pointer, decodes it to binary and reports occupancy/empty against the local pointer.
module gray_ptr_sync_decoder #(
    parameter int PTR_WIDTH   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [PTR_WIDTH-1:0] gray_ptr_in,
    input  logic [PTR_WIDTH-1:0] local_bin_ptr,
    input  logic                 err_clr,
    output logic [PTR_WIDTH-1:0] bin_ptr,
    output logic                 bin_valid,
    output logic [PTR_WIDTH-1:0] occupancy,
    output logic                 empty,
    output logic                 step_err,
    output logic                 err_sticky
);

    // Interface contract: there is no valid/ready handshake. gray_ptr_in is
    // sampled on every CLK edge, and every output is meaningful every cycle.
    // bin_valid qualifies bin_ptr once the synchronizer has refilled after reset.

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    logic [PTR_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [PTR_WIDTH-1:0] gray_s;
    logic [PTR_WIDTH-1:0] gray_prev;
    logic [PTR_WIDTH-1:0] bin_next;
    logic [PTR_WIDTH-1:0] gray_diff;
    logic                 multi_bit;
    logic                 step_next;
    logic [FILL_W-1:0]    fill_cnt;

    // Pure flop chain; nothing may sit between stages.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= gray_ptr_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign gray_s = sync_q[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_next = '0;
        for (int i = 0; i < PTR_WIDTH; i++) begin
            bin_next[i] = ^(gray_s >> i);
        end
    end

    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign gray_diff = gray_s ^ gray_prev;
    assign multi_bit = (gray_diff & (gray_diff - 1'b1)) != '0;
    assign step_next = bin_valid & multi_bit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bin_ptr    <= '0;
            gray_prev  <= '0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            bin_ptr    <= bin_next;
            gray_prev  <= gray_s;
            step_err   <= step_next;
            err_sticky <= step_next | (err_sticky & ~err_clr);
        end
    end

    // Refill counter: bin_valid rises on the (SYNC_STAGES+1)th edge after reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fill_cnt  <= '0;
            bin_valid <= 1'b0;
        end else if (!bin_valid) begin
            if (fill_cnt == FILL_W'(SYNC_STAGES)) begin
                bin_valid <= 1'b1;
            end else begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    assign occupancy = bin_ptr - local_bin_ptr;
    assign empty     = (bin_ptr == local_bin_ptr) | ~bin_valid;

endmodule
